// File: rtl/hp_arbiter.sv
// ============================================================================
//  Module   : hp_arbiter
//  Purpose  : Read/write burst arbiter onto AXI3 AR/AW channels with
//             outstanding-burst tracking and read-urgent priority override.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module hp_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int MAX_OUT   = 4,
    parameter int URGENT_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_req_valid_i,
    input  logic [ADDR_W-1:0] rd_req_addr_i,
    input  logic [3:0]        rd_req_len_i,
    output logic              rd_req_ready_o,
    input  logic              rd_urgent_i,
    input  logic              wr_req_valid_i,
    input  logic [ADDR_W-1:0] wr_req_addr_i,
    input  logic [3:0]        wr_req_len_i,
    output logic              wr_req_ready_o,
    output logic              m_axi_arvalid_o,
    output logic [ADDR_W-1:0] m_axi_araddr_o,
    output logic [3:0]        m_axi_arlen_o,
    input  logic              m_axi_arready_i,
    output logic              m_axi_awvalid_o,
    output logic [ADDR_W-1:0] m_axi_awaddr_o,
    output logic [3:0]        m_axi_awlen_o,
    input  logic              m_axi_awready_i,
    input  logic              m_axi_rvalid_i,
    input  logic              m_axi_rready_i,
    input  logic              m_axi_rlast_i,
    input  logic [1:0]        m_axi_rresp_i,
    input  logic [1:0]        m_axi_bresp_i,
    input  logic              m_axi_bvalid_i,
    output logic              m_axi_bready_o,
    output logic [3:0]        rd_out_o,
    output logic [3:0]        wr_out_o,
    output logic              err_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AR   = 2'd1;
    localparam logic [1:0] S_AW   = 2'd2;

    localparam logic [3:0] c_MAX_OUT = 4'(MAX_OUT);
    localparam logic [3:0] c_CNT_TOP = 4'hF;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_last_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [3:0]        r_rd_out;
    logic [3:0]        r_wr_out;
    logic              r_err;
    logic              r_bready;

    logic w_rd_elig, w_wr_elig;
    logic w_grant_rd, w_grant_wr;
    logic w_ar_hs, w_aw_hs, w_r_done, w_b_done;
    logic w_rd_uflow, w_wr_uflow, w_resp_err;

    assign w_rd_elig = rd_req_valid_i && (r_rd_out < c_MAX_OUT);
    assign w_wr_elig = wr_req_valid_i && (r_wr_out < c_MAX_OUT);

    assign w_ar_hs  = (r_state == S_AR) && m_axi_arready_i;
    assign w_aw_hs  = (r_state == S_AW) && m_axi_awready_i;
    assign w_r_done = m_axi_rvalid_i && m_axi_rready_i && m_axi_rlast_i;
    assign w_b_done = m_axi_bvalid_i && r_bready;

    assign w_rd_uflow = w_r_done && !w_ar_hs && (r_rd_out == 4'd0);
    assign w_wr_uflow = w_b_done && !w_aw_hs && (r_wr_out == 4'd0);
    assign w_resp_err = (m_axi_rvalid_i && m_axi_rready_i && (m_axi_rresp_i != 2'b00))
                      || (m_axi_bvalid_i && (m_axi_bresp_i != 2'b00));

    // Grants only from IDLE, so the handshake cycle always leaves a one-cycle bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_rd  = 1'b0;
        w_grant_wr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst_i) begin
                    if (w_rd_elig && w_wr_elig) begin
                        if (((URGENT_EN != 0) && rd_urgent_i) || r_last_wr)
                            w_grant_rd = 1'b1;
                        else
                            w_grant_wr = 1'b1;
                    end else begin
                        w_grant_rd = w_rd_elig;
                        w_grant_wr = w_wr_elig;
                    end
                end
                if (w_grant_rd)
                    w_state_nxt = S_AR;
                else if (w_grant_wr)
                    w_state_nxt = S_AW;
            end
            S_AR: if (m_axi_arready_i) w_state_nxt = S_IDLE;
            S_AW: if (m_axi_awready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_last_wr <= 1'b1;
            r_addr    <= '0;
            r_len     <= '0;
            r_rd_out  <= '0;
            r_wr_out  <= '0;
            r_err     <= 1'b0;
            r_bready  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bready <= 1'b1;
            r_err    <= r_err | w_rd_uflow | w_wr_uflow | w_resp_err;

            if (w_grant_rd) begin
                r_last_wr <= 1'b0;
                r_addr    <= rd_req_addr_i;
                r_len     <= rd_req_len_i;
            end else if (w_grant_wr) begin
                r_last_wr <= 1'b1;
                r_addr    <= wr_req_addr_i;
                r_len     <= wr_req_len_i;
            end

            // Simultaneous issue and completion cancel; counters saturate, never wrap.
            case ({w_ar_hs, w_r_done})
                2'b10:   if (r_rd_out != c_CNT_TOP) r_rd_out <= r_rd_out + 4'd1;
                2'b01:   if (r_rd_out != 4'd0)      r_rd_out <= r_rd_out - 4'd1;
                default: r_rd_out <= r_rd_out;
            endcase
            case ({w_aw_hs, w_b_done})
                2'b10:   if (r_wr_out != c_CNT_TOP) r_wr_out <= r_wr_out + 4'd1;
                2'b01:   if (r_wr_out != 4'd0)      r_wr_out <= r_wr_out - 4'd1;
                default: r_wr_out <= r_wr_out;
            endcase
        end
    end

    assign rd_req_ready_o  = w_grant_rd;
    assign wr_req_ready_o  = w_grant_wr;
    assign m_axi_arvalid_o = (r_state == S_AR);
    assign m_axi_araddr_o  = r_addr;
    assign m_axi_arlen_o   = r_len;
    assign m_axi_awvalid_o = (r_state == S_AW);
    assign m_axi_awaddr_o  = r_addr;
    assign m_axi_awlen_o   = r_len;
    assign m_axi_bready_o  = r_bready;
    assign rd_out_o        = r_rd_out;
    assign wr_out_o        = r_wr_out;
    assign err_o           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_hp_arbiter.sv
// ============================================================================
//  Module   : tb_hp_arbiter
//  Purpose  : Randomized self-checking bench for hp_arbiter against a
//             transaction-level reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hp_arbiter;

    localparam int ADDR_W  = 32;
    localparam int MAX_OUT = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              rd_req_valid_i, wr_req_valid_i;
    logic [ADDR_W-1:0] rd_req_addr_i, wr_req_addr_i;
    logic [3:0]        rd_req_len_i, wr_req_len_i;
    logic              rd_req_ready_o, wr_req_ready_o, rd_urgent_i;
    logic              m_axi_arvalid_o, m_axi_awvalid_o;
    logic [ADDR_W-1:0] m_axi_araddr_o, m_axi_awaddr_o;
    logic [3:0]        m_axi_arlen_o, m_axi_awlen_o;
    logic              m_axi_arready_i, m_axi_awready_i;
    logic              m_axi_rvalid_i, m_axi_rready_i, m_axi_rlast_i;
    logic [1:0]        m_axi_rresp_i, m_axi_bresp_i;
    logic              m_axi_bvalid_i, m_axi_bready_o;
    logic [3:0]        rd_out_o, wr_out_o;
    logic              err_o;

    always #5 clk_i = ~clk_i;

    hp_arbiter #(.ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT), .URGENT_EN(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_req_valid_i(rd_req_valid_i), .rd_req_addr_i(rd_req_addr_i),
        .rd_req_len_i(rd_req_len_i), .rd_req_ready_o(rd_req_ready_o),
        .rd_urgent_i(rd_urgent_i),
        .wr_req_valid_i(wr_req_valid_i), .wr_req_addr_i(wr_req_addr_i),
        .wr_req_len_i(wr_req_len_i), .wr_req_ready_o(wr_req_ready_o),
        .m_axi_arvalid_o(m_axi_arvalid_o), .m_axi_araddr_o(m_axi_araddr_o),
        .m_axi_arlen_o(m_axi_arlen_o), .m_axi_arready_i(m_axi_arready_i),
        .m_axi_awvalid_o(m_axi_awvalid_o), .m_axi_awaddr_o(m_axi_awaddr_o),
        .m_axi_awlen_o(m_axi_awlen_o), .m_axi_awready_i(m_axi_awready_i),
        .m_axi_rvalid_i(m_axi_rvalid_i), .m_axi_rready_i(m_axi_rready_i),
        .m_axi_rlast_i(m_axi_rlast_i), .m_axi_rresp_i(m_axi_rresp_i),
        .m_axi_bresp_i(m_axi_bresp_i), .m_axi_bvalid_i(m_axi_bvalid_i),
        .m_axi_bready_o(m_axi_bready_o),
        .rd_out_o(rd_out_o), .wr_out_o(wr_out_o), .err_o(err_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one pending address burst plus per-direction counts.
    bit          m_busy, m_is_rd, m_last_wr, m_err, m_bready;
    logic [31:0] m_addr;
    logic [3:0]  m_len;
    int          m_rd_out, m_wr_out;
    bit          rd_taken, wr_taken;

    // Stimulus knobs (percentages).
    int p_req, p_ready, p_urgent, p_resp, p_bad, p_rst;

    function automatic void model_reset();
        m_busy = 0; m_is_rd = 0; m_last_wr = 1; m_err = 0; m_bready = 0;
        m_rd_out = 0; m_wr_out = 0;
    endfunction

    function automatic int count_next(input int cnt, input bit up, input bit dn, inout bit err);
        int n;
        n = cnt + int'(up) - int'(dn);
        if (n < 0) begin
            err = 1;
            return cnt;
        end
        return (n > 15) ? cnt : n;
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic step();
        bit rd_el, wr_el, g_rd, g_wr, ar_hs, aw_hs, r_done, b_done;
        @(negedge clk_i);
        if (!rd_req_valid_i || rd_taken) begin
            rd_req_valid_i = pct(p_req);
            rd_req_addr_i  = $urandom;
            rd_req_len_i   = 4'($urandom);
        end
        if (!wr_req_valid_i || wr_taken) begin
            wr_req_valid_i = pct(p_req);
            wr_req_addr_i  = $urandom;
            wr_req_len_i   = 4'($urandom);
        end
        rd_urgent_i     = pct(p_urgent);
        m_axi_arready_i = pct(p_ready);
        m_axi_awready_i = pct(p_ready);
        m_axi_rvalid_i  = pct(p_resp);
        m_axi_rready_i  = pct(80);
        m_axi_rlast_i   = (m_rd_out > 0) ? pct(50) : pct(p_bad);
        m_axi_rresp_i   = pct(p_bad) ? 2'($urandom_range(3, 1)) : 2'b00;
        m_axi_bvalid_i  = (m_wr_out > 0) ? pct(p_resp) : pct(p_bad);
        m_axi_bresp_i   = pct(p_bad) ? 2'b10 : 2'b00;
        rst_i           = pct(p_rst);
        #1;

        rd_el = rd_req_valid_i && (m_rd_out < MAX_OUT);
        wr_el = wr_req_valid_i && (m_wr_out < MAX_OUT);
        g_rd = 0; g_wr = 0;
        if (!rst_i && !m_busy) begin
            if (rd_el && wr_el) begin
                if (rd_urgent_i || m_last_wr) g_rd = 1; else g_wr = 1;
            end else begin
                g_rd = rd_el;
                g_wr = wr_el;
            end
        end

        check("rd_ready", rd_req_ready_o, g_rd);
        check("wr_ready", wr_req_ready_o, g_wr);
        check("arvalid", m_axi_arvalid_o, m_busy && m_is_rd);
        check("awvalid", m_axi_awvalid_o, m_busy && !m_is_rd);
        if (m_busy && m_is_rd) begin
            check("araddr", m_axi_araddr_o, m_addr);
            check("arlen", m_axi_arlen_o, m_len);
        end
        if (m_busy && !m_is_rd) begin
            check("awaddr", m_axi_awaddr_o, m_addr);
            check("awlen", m_axi_awlen_o, m_len);
        end
        check("rd_out", rd_out_o, 64'(m_rd_out));
        check("wr_out", wr_out_o, 64'(m_wr_out));
        check("err", err_o, m_err);
        check("bready", m_axi_bready_o, m_bready);

        rd_taken = g_rd;
        wr_taken = g_wr;
        if (rst_i) begin
            model_reset();
        end else begin
            ar_hs  = m_busy && m_is_rd && m_axi_arready_i;
            aw_hs  = m_busy && !m_is_rd && m_axi_awready_i;
            r_done = m_axi_rvalid_i && m_axi_rready_i && m_axi_rlast_i;
            b_done = m_axi_bvalid_i && m_bready;
            if (m_axi_rvalid_i && m_axi_rready_i && m_axi_rresp_i != 2'b00) m_err = 1;
            if (m_axi_bvalid_i && m_axi_bresp_i != 2'b00) m_err = 1;
            m_rd_out = count_next(m_rd_out, ar_hs, r_done, m_err);
            m_wr_out = count_next(m_wr_out, aw_hs, b_done, m_err);
            if (ar_hs || aw_hs) begin
                m_busy = 0;
            end else if (g_rd || g_wr) begin
                m_busy    = 1;
                m_is_rd   = g_rd;
                m_last_wr = g_wr;
                m_addr    = g_rd ? rd_req_addr_i : wr_req_addr_i;
                m_len     = g_rd ? rd_req_len_i : wr_req_len_i;
            end
            m_bready = 1;
        end
    endtask

    task automatic run(input int n, input int req, input int rdy, input int urg,
                       input int resp, input int bad, input int rst);
        p_req = req; p_ready = rdy; p_urgent = urg; p_resp = resp; p_bad = bad; p_rst = rst;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst_i = 1; rd_req_valid_i = 0; wr_req_valid_i = 0;
        rd_req_addr_i = '0; wr_req_addr_i = '0; rd_req_len_i = '0; wr_req_len_i = '0;
        rd_urgent_i = 0; m_axi_arready_i = 0; m_axi_awready_i = 0;
        m_axi_rvalid_i = 0; m_axi_rready_i = 0; m_axi_rlast_i = 0;
        m_axi_rresp_i = '0; m_axi_bresp_i = '0; m_axi_bvalid_i = 0;
        rd_taken = 0; wr_taken = 0;
        repeat (2) @(posedge clk_i);
        model_reset();

        run(2, 0, 0, 0, 0, 0, 100);      // reset state
        run(16, 100, 100, 0, 0, 0, 0);   // plain round-robin alternation
        run(24, 100, 100, 100, 0, 0, 0); // urgent reads until the read limit
        run(60, 100, 8, 50, 20, 0, 0);   // long address-channel stalls
        run(40, 100, 100, 0, 100, 0, 0); // issue and completion colliding
        run(3000, 70, 60, 30, 40, 3, 1); // mixed traffic with errors and resets

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hp_arbiter.md
HP_ARBITER -- requirements
Module: hp_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all burst addresses.
REQ-002 Parameter MAX_OUT, default 4, maximum outstanding bursts per direction (range 1..15).
REQ-003 Parameter URGENT_EN, default 1, enables read-urgent priority override.
REQ-004 clk_i  in  1  single clock for all logic.
REQ-005 rst_i  in  1  synchronous reset, active-high.
REQ-006 rd_req_valid_i  in  1  read requester has a burst request.
REQ-007 rd_req_addr_i  in  ADDR_W  read burst start address.
REQ-008 rd_req_len_i  in  4  read burst AXI3 length (beats-1).
REQ-009 rd_req_ready_o  out  1  read request accepted this cycle.
REQ-010 rd_urgent_i  in  1  read line FIFO below low watermark.
REQ-011 wr_req_valid_i  in  1  write requester has a burst request.
REQ-012 wr_req_addr_i  in  ADDR_W  write burst start address.
REQ-013 wr_req_len_i  in  4  write burst AXI3 length.
REQ-014 wr_req_ready_o  out  1  write request accepted this cycle.
REQ-015 m_axi_arvalid_o / m_axi_araddr_o / m_axi_arlen_o  out  1/ADDR_W/4  AR channel; m_axi_arready_i in 1.
REQ-016 m_axi_awvalid_o / m_axi_awaddr_o / m_axi_awlen_o  out  1/ADDR_W/4  AW channel; m_axi_awready_i in 1.
REQ-017 m_axi_rvalid_i, m_axi_rready_i, m_axi_rlast_i  in  1 each  R-channel monitor (rready driven by read datapath).
REQ-018 m_axi_rresp_i, m_axi_bresp_i  in  2 each  response codes.
REQ-019 m_axi_bvalid_i  in  1; m_axi_bready_o  out  1  B channel, bready held 1 outside reset.
REQ-020 rd_out_o, wr_out_o  out  4 each  outstanding burst counts.
REQ-021 err_o  out  1  sticky error flag.

Function
REQ-022 FSM states IDLE, AR, AW; only one address channel valid at any cycle.
REQ-023 Eligibility: rd eligible = rd_req_valid_i && rd_out_o<MAX_OUT; wr eligible = wr_req_valid_i && wr_out_o<MAX_OUT.
REQ-024 IDLE grant: both eligible -> rd if URGENT_EN && rd_urgent_i, else the side not granted last (round-robin, last-grant reset value = wr so rd wins first tie); one eligible -> that side; none -> stay IDLE.
REQ-025 On grant, req_ready_o of granted side pulses 1 for exactly that cycle; addr/len captured into register; next state AR or AW.
REQ-026 AR/AW: valid held 1, addr/len stable until ready; on valid&&ready return to IDLE next cycle; no new grant in the handshake cycle (min 2 cycles per burst, 1 idle-cycle bubble).
REQ-027 rd_out_o: +1 on AR handshake, -1 on rvalid&&rready&&rlast, unchanged when both same cycle; wr_out_o likewise with AW handshake and bvalid&&bready.
REQ-028 Decrement at count 0 is ignored and sets err_o; counters never wrap.
REQ-029 err_o set on rresp!=0 with rvalid&&rready, or bresp!=0 with bvalid; cleared only by reset.
REQ-030 Requests arriving while in AR/AW are not acknowledged; requester holds valid (no drop).
REQ-031 Urgent override only affects IDLE decision; a burst already in AW is never preempted.

Reset
REQ-032 On rst_i=1 at clock edge: state IDLE, all valids/readies 0, counters 0, err_o 0, last-grant = wr, bready 0.
REQ-033 Reset asserted mid-handshake abandons the burst; counters are cleared regardless of in-flight responses.

Verification
REQ-034 Both valid, urgent=0, ready always 1 -> grants alternate rd,wr,rd,wr; each burst 2 cycles.
REQ-035 Both valid, rd_urgent_i=1 -> four consecutive AR bursts, then rd blocked at rd_out_o=4, wr granted next.
REQ-036 AR issued, arready held 0 for 10 cycles -> araddr/arlen stable, arvalid=1 throughout, no wr_req_ready pulse.
REQ-037 rd_out_o=2, AR handshake and rlast beat same cycle -> rd_out_o stays 2.
REQ-038 bresp=2'b10 with bvalid -> err_o=1 next cycle, remains 1 until rst_i.
REQ-039 rst_i pulsed while awvalid=1, wr_out_o=3 -> next cycle awvalid=0, wr_out_o=0, state IDLE.
